shift_register_deser: RTL and testbench
=======================================

SHIFT_REGISTER_DESER -- requirements
Module: shift_register_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4: word width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port clear, input, 1 bit: synchronous abort of the partial word and of the overrun flag.
REQ-005 SHALL have port bit_valid, input, 1 bit: serial_in carries a valid bit this cycle.
REQ-006 SHALL have port serial_in, input, 1 bit: serial data, LSB of each word first, matching the right-shift transmitter's output order.
REQ-007 SHALL have port word_ack, input, 1 bit: consumer accepts the held word.
REQ-008 SHALL have port data_out, output, WIDTH bits: last completed word.
REQ-009 SHALL have port word_valid, output, 1 bit: data_out holds an unacknowledged word.
REQ-010 SHALL have port busy, output, 1 bit: a partial word is in progress (bit count nonzero).
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, set when a word was lost.

Function
REQ-012 SHALL keep an internal shift register sreg[WIDTH-1:0] and a bit counter cnt, with range 0..WIDTH-1 and $clog2(WIDTH) bits.
REQ-013 On bit_valid=1, SHALL shift right with serial_in entering the MSB: sreg <= {serial_in, sreg[WIDTH-1:1]}.
REQ-014 After WIDTH valid bits, the first received bit SHALL sit in data_out[0].
REQ-015 On bit_valid=0, SHALL hold sreg and cnt; gaps between bits are legal and of any length.
REQ-016 SHALL use FSM states IDLE (cnt=0, busy=0) and RECV (0<cnt<WIDTH, busy=1).
- IDLE->RECV on the first valid bit.
- RECV->IDLE on the WIDTH-th valid bit.
REQ-017 On the WIDTH-th valid bit:
- the next edge loads data_out <= {serial_in, sreg[WIDTH-1:1]};
- sets word_valid=1 and cnt=0.
- Latency is 1 clock from the last bit edge to word_valid=1.
REQ-018 word_valid SHALL remain 1, and data_out stable, until a cycle with word_ack=1.
- That edge clears word_valid, unless REQ-019 applies.
REQ-019 If a word completes in the same cycle as word_ack=1, SHALL load the new word, keep word_valid=1 and leave overrun unchanged.
REQ-020 If a word completes while word_valid=1 and word_ack=0:
- SHALL overwrite data_out with the new word;
- SHALL keep word_valid=1;
- SHALL set overrun=1.
REQ-021 overrun SHALL clear only on clear=1 or on reset.
REQ-022 word_ack while word_valid=0 SHALL have no effect.
REQ-023 clear=1 SHALL have priority over bit_valid in the same cycle:
- cnt=0, sreg=0, overrun=0, state IDLE, and the incoming bit is discarded;
- data_out and word_valid are unaffected.
REQ-024 The WIDTH-1 count wraps to 0 only through word completion; cnt SHALL never exceed WIDTH-1.

Reset
REQ-025 While rst=0, SHALL force asynchronously: sreg=0, cnt=0, data_out=0, word_valid=0, busy=0, overrun=0, state IDLE.
REQ-026 Reset asserted mid-word SHALL discard the partial word.
- After release, reception restarts with the next valid bit as bit 0.
REQ-027 SHALL ignore inputs on the first edge where rst is already 1; no special release sequencing is required.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE, RECV) in a shared package, shift_reg_pkg.
- The default word width constant SHALL also live there, for reuse by the matching right-shift transmitter.
REQ-029 SHALL factor out a single sub-module, bit_counter: modulo-WIDTH counter with enable, synchronous clear and a terminal-count output.
- sreg, the holding register and the flags stay in the top level.
REQ-030 SHALL be fully synchronous to clk apart from rst; no latches and no combinational paths from inputs to outputs.

Verification
REQ-031 Basic word:
- Stimulus: serial bits 1,1,0,1 on consecutive cycles with bit_valid=1.
- Response: data_out=4'b1011 and word_valid=1 one cycle after the 4th bit; busy=1 during bits 2-4.
REQ-032 Gapped input:
- Stimulus: 0,0,1,1 with 3 idle cycles between bits.
- Response: data_out=4'b1100; busy held through the gaps.
REQ-033 Overrun:
- Stimulus: word 4'b1011, no ack, then word 4'b0110.
- Response: data_out=4'b0110, word_valid=1, overrun=1.
- Then clear=1: overrun=0, data_out unchanged.
REQ-034 Ack collision: word_ack=1 on the completion cycle of the second word -> word_valid stays 1 and overrun stays 0.
REQ-035 Abort:
- clear=1 after 2 bits -> busy=0.
- Next 4 bits 1,0,0,0 -> data_out=4'b0001.
REQ-036 Reset mid-word: rst=0 after 3 bits -> all outputs 0 immediately, without waiting for a clock edge; a following full word is received correctly.
REQ-037 Loopback: the right-shift register (parallel load 4'b1011, shifting out its LSB) feeds serial_in with bit_valid=shift -> data_out=4'b1011.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial deserializer and its matching right-shift transmitter.
// Holds the FSM state encoding and the default word width.
package shift_reg_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

endpackage : shift_reg_pkg

// File: rtl/shift_register_deser_bit_counter.sv
// Modulo-WIDTH bit counter with enable and synchronous clear.
// o_tc flags the last count before wrap, so the caller can detect word completion.
module bit_counter
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_clr,
   input  logic                     i_en,
   output logic [$clog2(WIDTH)-1:0] o_cnt,
   output logic                     o_tc
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == CW'(WIDTH - 1));

endmodule : bit_counter

// File: rtl/shift_register_deser.sv
// Serial-to-parallel deserializer: LSB-first bits are shifted in from the MSB end and
// each completed word is held with a valid/ack handshake and a sticky overrun flag.
module shift_register_deser
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             bit_valid,
   input  logic             serial_in,
   input  logic             word_ack,
   output logic [WIDTH-1:0] data_out,
   output logic             word_valid,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] r_data;
   logic             r_word_valid;
   logic             r_overrun;

   logic [CW-1:0]    w_cnt;
   logic             w_tc;
   logic             w_shift;
   logic             w_word_done;
   logic [WIDTH-1:0] w_next_word;

   // clear wins over an incoming bit, so a bit arriving with clear is dropped.
   assign w_shift     = bit_valid & ~clear;
   assign w_word_done = w_shift & w_tc;
   assign w_next_word = {serial_in, r_sreg[WIDTH-1:1]};

   bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk   (clk),
      .rst   (rst),
      .i_clr (clear),
      .i_en  (w_shift),
      .o_cnt (w_cnt),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: next-state is defaulted first so no path through this block can infer a latch.
   always_comb begin
      w_state_next = r_state;
      if (clear) begin
         w_state_next = IDLE;
      end else if (bit_valid) begin
         unique case (r_state)
            IDLE:    w_state_next = RECV;
            RECV:    w_state_next = w_tc ? IDLE : RECV;
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sreg <= '0;
      end else if (clear) begin
         r_sreg <= '0;
      end else if (bit_valid) begin
         r_sreg <= w_next_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data       <= '0;
         r_word_valid <= 1'b0;
      end else if (w_word_done) begin
         r_data       <= w_next_word;
         r_word_valid <= 1'b1;
      end else if (word_ack) begin
         r_word_valid <= 1'b0;
      end
   end

   // A word is lost only when the previous one is still held and not being acked.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overrun <= 1'b0;
      end else if (clear) begin
         r_overrun <= 1'b0;
      end else if (w_word_done && r_word_valid && !word_ack) begin
         r_overrun <= 1'b1;
      end
   end

   assign data_out   = r_data;
   assign word_valid = r_word_valid;
   assign busy       = (r_state == RECV);
   assign overrun    = r_overrun;

   a_state_tracks_cnt : assert property (@(posedge clk) disable iff (!rst)
      ((r_state == RECV) == (w_cnt != '0)) && (w_cnt <= CW'(WIDTH - 1)));

endmodule : shift_register_deser

// File: tb/tb_shift_register_deser.sv
// Directed bench for shift_register_deser (WIDTH=4): a vector table of per-cycle
// inputs and expected outputs, plus hand sequences for async reset and loopback.
module tb_shift_register_deser;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic       bit_valid;
   logic       serial_in;
   logic       word_ack;
   logic [3:0] data_out;
   logic       word_valid;
   logic       busy;
   logic       overrun;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic       clr;
      logic       v;
      logic       s;
      logic       ack;
      logic [3:0] dout;
      logic       wv;
      logic       busy;
      logic       ov;
   } vec_t;

   vec_t vecs[$];

   shift_register_deser #(
      .WIDTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .bit_valid  (bit_valid),
      .serial_in  (serial_in),
      .word_ack   (word_ack),
      .data_out   (data_out),
      .word_valid (word_valid),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic void add(input logic c, input logic v, input logic s, input logic a,
                               input logic [3:0] d, input logic wv, input logic b, input logic ov);
      vec_t t;
      t.clr = c; t.v = v; t.s = s; t.ack = a;
      t.dout = d; t.wv = wv; t.busy = b; t.ov = ov;
      vecs.push_back(t);
   endfunction

   task automatic drive(input logic c, input logic v, input logic s, input logic a);
      clear = c; bit_valid = v; serial_in = s; word_ack = a;
   endtask

   task automatic cycle(input logic c, input logic v, input logic s, input logic a);
      drive(c, v, s, a);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] tx_reg;
      logic [3:0] shift_pat;
      int         budget;

      rst = 1'b0;
      drive(0, 0, 0, 0);

      //   clr v s ack | dout wv busy ov
      // basic word 1,1,0,1
      add(0,1,1,0, 4'b0000,0,1,0);
      add(0,1,1,0, 4'b0000,0,1,0);
      add(0,1,0,0, 4'b0000,0,1,0);
      add(0,1,1,0, 4'b1011,1,0,0);
      add(0,0,0,1, 4'b1011,0,0,0);
      // gapped word 0,0,1,1 with three idle cycles between bits
      add(0,1,0,0, 4'b1011,0,1,0);
      for (int k = 0; k < 3; k++) add(0,0,0,0, 4'b1011,0,1,0);
      add(0,1,0,0, 4'b1011,0,1,0);
      for (int k = 0; k < 3; k++) add(0,0,0,0, 4'b1011,0,1,0);
      add(0,1,1,0, 4'b1011,0,1,0);
      for (int k = 0; k < 3; k++) add(0,0,0,0, 4'b1011,0,1,0);
      add(0,1,1,0, 4'b1100,1,0,0);
      add(0,0,0,1, 4'b1100,0,0,0);
      // overrun: 1011 unacked, then 0110
      add(0,1,1,0, 4'b1100,0,1,0);
      add(0,1,1,0, 4'b1100,0,1,0);
      add(0,1,0,0, 4'b1100,0,1,0);
      add(0,1,1,0, 4'b1011,1,0,0);
      add(0,1,0,0, 4'b1011,1,1,0);
      add(0,1,1,0, 4'b1011,1,1,0);
      add(0,1,1,0, 4'b1011,1,1,0);
      add(0,1,0,0, 4'b0110,1,0,1);
      add(1,0,0,0, 4'b0110,1,0,0);
      // ack collision on completion of the second word
      add(0,0,0,1, 4'b0110,0,0,0);
      add(0,1,1,0, 4'b0110,0,1,0);
      add(0,1,1,0, 4'b0110,0,1,0);
      add(0,1,0,0, 4'b0110,0,1,0);
      add(0,1,1,0, 4'b1011,1,0,0);
      add(0,1,0,0, 4'b1011,1,1,0);
      add(0,1,1,0, 4'b1011,1,1,0);
      add(0,1,1,0, 4'b1011,1,1,0);
      add(0,1,0,1, 4'b0110,1,0,0);
      // ack with nothing held
      add(0,0,0,1, 4'b0110,0,0,0);
      add(0,0,0,1, 4'b0110,0,0,0);
      // abort after two bits; clear beats a simultaneous valid bit
      add(0,1,1,0, 4'b0110,0,1,0);
      add(0,1,1,0, 4'b0110,0,1,0);
      add(1,1,1,0, 4'b0110,0,0,0);
      add(0,1,1,0, 4'b0110,0,1,0);
      add(0,1,0,0, 4'b0110,0,1,0);
      add(0,1,0,0, 4'b0110,0,1,0);
      add(0,1,0,0, 4'b0001,1,0,0);

      repeat (2) @(posedge clk);
      #1;
      check("reset.data_out", 32'(data_out), 32'h0);
      check("reset.word_valid", 32'(word_valid), 32'h0);
      check("reset.busy", 32'(busy), 32'h0);
      check("reset.overrun", 32'(overrun), 32'h0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         cycle(vecs[i].clr, vecs[i].v, vecs[i].s, vecs[i].ack);
         check($sformatf("v%0d.data_out", i), 32'(data_out), 32'(vecs[i].dout));
         check($sformatf("v%0d.word_valid", i), 32'(word_valid), 32'(vecs[i].wv));
         check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
         check($sformatf("v%0d.overrun", i), 32'(overrun), 32'(vecs[i].ov));
      end

      // Reset mid-word while word 0001 is still held: outputs must drop before any edge.
      cycle(0, 1, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 0);
      check("pre_rst.busy", 32'(busy), 32'h1);
      drive(0, 0, 0, 0);
      #1 rst = 1'b0;
      #1;
      check("async_rst.data_out", 32'(data_out), 32'h0);
      check("async_rst.word_valid", 32'(word_valid), 32'h0);
      check("async_rst.busy", 32'(busy), 32'h0);
      check("async_rst.overrun", 32'(overrun), 32'h0);
      #1 rst = 1'b1;
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 0);
      cycle(0, 1, 1, 0);
      check("post_rst.busy", 32'(busy), 32'h1);
      cycle(0, 1, 1, 0);
      check("post_rst.data_out", 32'(data_out), 32'hE);
      check("post_rst.word_valid", 32'(word_valid), 32'h1);
      check("post_rst.overrun", 32'(overrun), 32'h0);

      // Loopback from a right-shift transmitter loaded with 1011, shifting with gaps.
      cycle(0, 0, 0, 1);
      tx_reg    = 4'b1011;
      shift_pat = 4'b0000;
      budget    = 0;
      while (!word_valid && budget < 20) begin
         shift_pat = budget[0] ? 4'b0001 : 4'b0000;
         drive(0, shift_pat[0], tx_reg[0], 0);
         @(posedge clk);
         if (shift_pat[0]) tx_reg = {1'b0, tx_reg[3:1]};
         #1;
         budget++;
      end
      check("loopback.timeout", 32'(word_valid), 32'h1);
      check("loopback.data_out", 32'(data_out), 32'hB);
      check("loopback.overrun", 32'(overrun), 32'h0);
      check("loopback.busy", 32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_shift_register_deser
